// File: rtl/sd_host_regs_pkg.sv
// Shared constants for the SD host register bank: register map addresses,
// named bit positions and a small masked-OR helper.
package sd_host_regs_pkg;

   localparam int REG_W = 32;
   localparam int ADR_W = 5;

   localparam logic [ADR_W-1:0] ADR_ARGUMENT      = 5'd0;
   localparam logic [ADR_W-1:0] ADR_COMMAND       = 5'd1;
   localparam logic [ADR_W-1:0] ADR_BLOCK         = 5'd2;
   localparam logic [ADR_W-1:0] ADR_XFER_MODE     = 5'd3;
   localparam logic [ADR_W-1:0] ADR_RESPONSE0     = 5'd4;
   localparam logic [ADR_W-1:0] ADR_RESPONSE1     = 5'd5;
   localparam logic [ADR_W-1:0] ADR_RESPONSE2     = 5'd6;
   localparam logic [ADR_W-1:0] ADR_RESPONSE3     = 5'd7;
   localparam logic [ADR_W-1:0] ADR_PRESENT_STATE = 5'd8;
   localparam logic [ADR_W-1:0] ADR_HOST_CTRL     = 5'd9;
   localparam logic [ADR_W-1:0] ADR_CLK_CTRL      = 5'd10;
   localparam logic [ADR_W-1:0] ADR_SW_RESET      = 5'd11;
   localparam logic [ADR_W-1:0] ADR_NIS           = 5'd12;
   localparam logic [ADR_W-1:0] ADR_EIS           = 5'd13;
   localparam logic [ADR_W-1:0] ADR_NIE           = 5'd14;
   localparam logic [ADR_W-1:0] ADR_EIE           = 5'd15;

   localparam int CMD_INHIBIT_BIT      = 0;
   localparam int NIS_CMD_COMPLETE_BIT = 0;
   localparam int NIS_ERR_SUMMARY_BIT  = 15;
   localparam int SW_RESET_ALL_BIT     = 0;

   function automatic logic masked_any(input logic [15:0] status, input logic [15:0] enable);
      return |(status & enable);
   endfunction

endpackage

// File: rtl/w1c_status_reg.sv
// 16-bit sticky status register: hardware sets accumulate, a bus write clears
// the bits written as 1, and a set in the same cycle as a clear wins.
module w1c_status_reg (
   input  logic        clock,
   input  logic        reset,
   input  logic        srst,
   input  logic [15:0] set_bits,
   input  logic        clear_en,
   input  logic [15:0] clear_bits,
   output logic [15:0] status
);

   logic [15:0] status_r;
   logic [15:0] clear_mask_s;

   // Clear mask is only live during a write to this register
   always_comb begin
      if (clear_en) begin
         clear_mask_s = clear_bits;
      end else begin
         clear_mask_s = 16'h0000;
      end
   end

   // Sticky accumulate; OR-ing the set after the clear gives set-wins
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         status_r <= 16'h0000;
      end else if (srst) begin
         status_r <= 16'h0000;
      end else begin
         status_r <= (status_r & ~clear_mask_s) | set_bits;
      end
   end

   assign status = status_r;

endmodule

// File: rtl/sd_host_register_bank.sv
// Host-side register bank of the SD host controller: control/status map,
// response capture, sticky interrupt status and command launch.
module sd_host_register_bank
   import sd_host_regs_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic [ADR_W-1:0]   adr_i,
   input  logic               reg_write_en,
   input  logic               reg_read_en,
   input  logic [127:0]       data_i,
   input  logic               command_complete,
   input  logic [127:0]       response_i,
   input  logic [15:0]        error_interrupt_status_i,
   input  logic [15:0]        normal_interrupt_status_i,
   output logic [REG_W-1:0]   data_o,
   output logic               read_valid,
   output logic               cmd_start,
   output logic [REG_W-1:0]   argument_o,
   output logic [15:0]        command_o,
   output logic               interrupt_o
);

   logic [REG_W-1:0] argument_r, block_r, xfer_mode_r, host_ctrl_r, clk_ctrl_r, sw_reset_r;
   logic [15:0]      command_r, nie_r, eie_r;
   logic [127:0]     response_r;
   logic             cmd_inhibit_r, cc_prev_r, cmd_start_r, read_valid_r, interrupt_r;
   logic [REG_W-1:0] data_r, rd_data_s, wdata_s;
   logic [15:0]      nis_set_s, nis_stat_s, eis_stat_s, nis_view_s;
   logic             srst_s, wr_en_s, cc_event_s, cmd_accept_s, irq_s;
   logic             nis_clr_en_s, eis_clr_en_s;
   logic             unused_data_hi_s;

   // The soft-reset cycle swallows bus writes and hardware events
   assign srst_s           = sw_reset_r[SW_RESET_ALL_BIT];
   assign wr_en_s          = reg_write_en & ~srst_s;
   assign wdata_s          = data_i[REG_W-1:0];
   assign unused_data_hi_s = ^data_i[127:REG_W];
   assign cc_event_s       = command_complete & ~cc_prev_r & ~srst_s;
   assign cmd_accept_s     = wr_en_s & (adr_i == ADR_COMMAND) & ~cmd_inhibit_r;
   assign nis_clr_en_s     = wr_en_s & (adr_i == ADR_NIS);
   assign eis_clr_en_s     = wr_en_s & (adr_i == ADR_EIS);

   // NIS hardware sets: raw events plus completion; bit15 is never stored
   always_comb begin
      nis_set_s = normal_interrupt_status_i;
      nis_set_s[NIS_ERR_SUMMARY_BIT] = 1'b0;
      nis_set_s[NIS_CMD_COMPLETE_BIT] = nis_set_s[NIS_CMD_COMPLETE_BIT] | cc_event_s;
   end

   w1c_status_reg u_nis (
      .clock      (clock),
      .reset      (reset),
      .srst       (srst_s),
      .set_bits   (nis_set_s),
      .clear_en   (nis_clr_en_s),
      .clear_bits (wdata_s[15:0]),
      .status     (nis_stat_s)
   );

   w1c_status_reg u_eis (
      .clock      (clock),
      .reset      (reset),
      .srst       (srst_s),
      .set_bits   (error_interrupt_status_i),
      .clear_en   (eis_clr_en_s),
      .clear_bits (wdata_s[15:0]),
      .status     (eis_stat_s)
   );

   // NIS as seen by software: bit15 is the live error summary
   always_comb begin
      nis_view_s = nis_stat_s;
      nis_view_s[NIS_ERR_SUMMARY_BIT] = |eis_stat_s;
   end

   assign irq_s = masked_any(nis_view_s, nie_r) | masked_any(eis_stat_s, eie_r);

   // Control registers: soft-reset flush, bus writes, completion capture
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         argument_r    <= 32'h0000_0000;
         command_r     <= 16'h0000;
         block_r       <= 32'h0000_0000;
         xfer_mode_r   <= 32'h0000_0000;
         host_ctrl_r   <= 32'h0000_0000;
         clk_ctrl_r    <= 32'h0000_0000;
         sw_reset_r    <= 32'h0000_0000;
         nie_r         <= 16'h0000;
         eie_r         <= 16'h0000;
         response_r    <= 128'h0;
         cmd_inhibit_r <= 1'b0;
         cmd_start_r   <= 1'b0;
      end else if (srst_s) begin
         argument_r    <= 32'h0000_0000;
         command_r     <= 16'h0000;
         block_r       <= 32'h0000_0000;
         xfer_mode_r   <= 32'h0000_0000;
         host_ctrl_r   <= 32'h0000_0000;
         clk_ctrl_r    <= 32'h0000_0000;
         sw_reset_r[SW_RESET_ALL_BIT] <= 1'b0;
         nie_r         <= 16'h0000;
         eie_r         <= 16'h0000;
         response_r    <= 128'h0;
         cmd_inhibit_r <= 1'b0;
         cmd_start_r   <= 1'b0;
      end else begin
         if (wr_en_s) begin
            case (adr_i)
               ADR_ARGUMENT:  argument_r  <= wdata_s;
               ADR_COMMAND:   if (!cmd_inhibit_r) command_r <= wdata_s[15:0];
               ADR_BLOCK:     block_r     <= wdata_s;
               ADR_XFER_MODE: xfer_mode_r <= wdata_s;
               ADR_HOST_CTRL: host_ctrl_r <= wdata_s;
               ADR_CLK_CTRL:  clk_ctrl_r  <= wdata_s;
               ADR_SW_RESET:  sw_reset_r  <= wdata_s;
               ADR_NIE:       nie_r       <= wdata_s[15:0];
               ADR_EIE:       eie_r       <= wdata_s[15:0];
               default:       ;
            endcase
         end
         if (cc_event_s) begin
            response_r <= response_i;
         end
         // A newly launched command outranks a stale completion edge
         if (cmd_accept_s) begin
            cmd_inhibit_r <= 1'b1;
         end else if (cc_event_s) begin
            cmd_inhibit_r <= 1'b0;
         end
         cmd_start_r <= cmd_accept_s;
      end
   end

   // Read mux over the pre-edge register values
   always_comb begin
      rd_data_s = 32'h0000_0000;
      case (adr_i)
         ADR_ARGUMENT:      rd_data_s = argument_r;
         ADR_COMMAND:       rd_data_s = {16'h0000, command_r};
         ADR_BLOCK:         rd_data_s = block_r;
         ADR_XFER_MODE:     rd_data_s = xfer_mode_r;
         ADR_RESPONSE0:     rd_data_s = response_r[31:0];
         ADR_RESPONSE1:     rd_data_s = response_r[63:32];
         ADR_RESPONSE2:     rd_data_s = response_r[95:64];
         ADR_RESPONSE3:     rd_data_s = response_r[127:96];
         ADR_PRESENT_STATE: rd_data_s[CMD_INHIBIT_BIT] = cmd_inhibit_r;
         ADR_HOST_CTRL:     rd_data_s = host_ctrl_r;
         ADR_CLK_CTRL:      rd_data_s = clk_ctrl_r;
         ADR_SW_RESET:      rd_data_s = sw_reset_r;
         ADR_NIS:           rd_data_s = {16'h0000, nis_view_s};
         ADR_EIS:           rd_data_s = {16'h0000, eis_stat_s};
         ADR_NIE:           rd_data_s = {16'h0000, nie_r};
         ADR_EIE:           rd_data_s = {16'h0000, eie_r};
         default:           rd_data_s = 32'h0000_0000;
      endcase
   end

   // Read port, interrupt line and completion edge detector
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_r       <= 32'h0000_0000;
         read_valid_r <= 1'b0;
         interrupt_r  <= 1'b0;
         cc_prev_r    <= 1'b0;
      end else begin
         read_valid_r <= reg_read_en;
         if (reg_read_en) begin
            data_r <= rd_data_s;
         end
         interrupt_r <= irq_s;
         cc_prev_r   <= command_complete;
      end
   end

   assign data_o      = data_r;
   assign read_valid  = read_valid_r;
   assign cmd_start   = cmd_start_r;
   assign argument_o  = argument_r;
   assign command_o   = command_r;
   assign interrupt_o = interrupt_r;

endmodule

// File: tb/tb_sd_host_register_bank.sv
// Self-checking bench for sd_host_register_bank: directed sequences, a
// write/readback vector table and a randomized run against a reference model.
module tb_sd_host_register_bank;

   logic         clock = 1'b0;
   logic         reset;
   logic [4:0]   adr_i;
   logic         reg_write_en, reg_read_en;
   logic [127:0] data_i, response_i;
   logic         command_complete;
   logic [15:0]  error_interrupt_status_i, normal_interrupt_status_i;
   logic [31:0]  data_o, argument_o;
   logic         read_valid, cmd_start, interrupt_o;
   logic [15:0]  command_o;

   int n_checks = 0;
   int n_fail   = 0;

   sd_host_register_bank dut (
      .clock                     (clock),
      .reset                     (reset),
      .adr_i                     (adr_i),
      .reg_write_en              (reg_write_en),
      .reg_read_en               (reg_read_en),
      .data_i                    (data_i),
      .command_complete          (command_complete),
      .response_i                (response_i),
      .error_interrupt_status_i  (error_interrupt_status_i),
      .normal_interrupt_status_i (normal_interrupt_status_i),
      .data_o                    (data_o),
      .read_valid                (read_valid),
      .cmd_start                 (cmd_start),
      .argument_o                (argument_o),
      .command_o                 (command_o),
      .interrupt_o               (interrupt_o)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  adr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [13];

   // reference model state
   logic [31:0]  m_arg, m_blk, m_xfer, m_host, m_clk, m_dout;
   logic [15:0]  m_cmd, m_nis, m_eis, m_nie, m_eie;
   logic [127:0] m_resp;
   logic         m_inh, m_cc_prev;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      adr_i = 5'd0;
      reg_write_en = 1'b0;
      reg_read_en = 1'b0;
      data_i = 128'h0;
      response_i = 128'h0;
      command_complete = 1'b0;
      error_interrupt_status_i = 16'h0000;
      normal_interrupt_status_i = 16'h0000;
   endtask

   task automatic hard_reset();
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      adr_i = a;
      data_i = {96'h0, d};
      reg_write_en = 1'b1;
      tick();
      reg_write_en = 1'b0;
   endtask

   task automatic do_read(input string name, input logic [4:0] a, input logic [31:0] exp);
      adr_i = a;
      reg_read_en = 1'b1;
      tick();
      reg_read_en = 1'b0;
      check({name, "_valid"}, {31'h0, read_valid}, 32'h1);
      check(name, data_o, exp);
   endtask

   function automatic logic [15:0] m_nis_view();
      return {|m_eis, m_nis[14:0]};
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      int idx;
      case (a)
         5'd0:  return m_arg;
         5'd1:  return {16'h0, m_cmd};
         5'd2:  return m_blk;
         5'd3:  return m_xfer;
         5'd4, 5'd5, 5'd6, 5'd7: begin
            idx = int'(a) - 4;
            return m_resp[32*idx +: 32];
         end
         5'd8:  return {31'h0, m_inh};
         5'd9:  return m_host;
         5'd10: return m_clk;
         5'd11: return 32'h0;
         5'd12: return {16'h0, m_nis_view()};
         5'd13: return {16'h0, m_eis};
         5'd14: return {16'h0, m_nie};
         5'd15: return {16'h0, m_eie};
         default: return 32'h0;
      endcase
   endfunction

   initial begin
      vecs[0]  = '{5'd0,  32'h0000_0002, 32'h0000_0002};
      vecs[1]  = '{5'd2,  32'h1234_5678, 32'h1234_5678};
      vecs[2]  = '{5'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[3]  = '{5'd9,  32'h0000_00A5, 32'h0000_00A5};
      vecs[4]  = '{5'd10, 32'h0000_BEEF, 32'h0000_BEEF};
      vecs[5]  = '{5'd14, 32'hFFFF_1234, 32'h0000_1234};
      vecs[6]  = '{5'd15, 32'hABCD_0F0F, 32'h0000_0F0F};
      vecs[7]  = '{5'd4,  32'h0000_DEAD, 32'h0000_0000};
      vecs[8]  = '{5'd7,  32'hFFFF_FFFF, 32'h0000_0000};
      vecs[9]  = '{5'd8,  32'h0000_0001, 32'h0000_0000};
      vecs[10] = '{5'd20, 32'h0000_0055, 32'h0000_0000};
      vecs[11] = '{5'd16, 32'h0000_0001, 32'h0000_0000};
      vecs[12] = '{5'd5,  32'hFFFF_FFFF, 32'h0000_0000};

      idle_inputs();
      reset = 1'b0;
      #2;
      check("rst_data_o", data_o, 32'h0);
      check("rst_read_valid", {31'h0, read_valid}, 32'h0);
      check("rst_cmd_start", {31'h0, cmd_start}, 32'h0);
      check("rst_interrupt", {31'h0, interrupt_o}, 32'h0);
      check("rst_argument", argument_o, 32'h0);
      check("rst_command", {16'h0, command_o}, 32'h0);
      tick();
      reset = 1'b1;
      tick();

      // basic write/readback and read_valid timing
      do_write(5'd0, 32'h0000_0002);
      do_read("arg_read", 5'd0, 32'h0000_0002);
      tick();
      check("read_valid_idle", {31'h0, read_valid}, 32'h0);
      check("data_o_hold", data_o, 32'h0000_0002);
      do_write(5'd5, 32'hFFFF_FFFF);
      do_read("resp1_ro", 5'd5, 32'h0);

      // command launch, inhibit and completion
      do_write(5'd1, 32'h0000_0011);
      check("cmd_start_pulse", {31'h0, cmd_start}, 32'h1);
      check("command_o", {16'h0, command_o}, 32'h0000_0011);
      tick();
      check("cmd_start_one_cycle", {31'h0, cmd_start}, 32'h0);
      do_read("present_inhibit", 5'd8, 32'h1);
      do_write(5'd1, 32'h0000_0022);
      check("cmd_start_blocked", {31'h0, cmd_start}, 32'h0);
      do_read("command_unchanged", 5'd1, 32'h0000_0011);
      response_i = {32'd4, 32'd3, 32'd2, 32'd1};
      command_complete = 1'b1;
      tick();
      response_i = 128'h0;
      do_read("resp0", 5'd4, 32'd1);
      do_read("resp1", 5'd5, 32'd2);
      do_read("resp2", 5'd6, 32'd3);
      do_read("resp3", 5'd7, 32'd4);
      do_read("nis_cc", 5'd12, 32'h0000_0001);
      do_read("present_clear", 5'd8, 32'h0);

      // interrupt enable, W1C with level still high, registered interrupt
      do_write(5'd14, 32'h0000_0001);
      tick();
      check("irq_raised", {31'h0, interrupt_o}, 32'h1);
      do_write(5'd12, 32'h0000_0001);
      check("irq_lags_clear", {31'h0, interrupt_o}, 32'h1);
      tick();
      check("irq_fell", {31'h0, interrupt_o}, 32'h0);
      do_read("nis_cleared_level_high", 5'd12, 32'h0);
      command_complete = 1'b0;
      error_interrupt_status_i = 16'h0001;
      tick();
      error_interrupt_status_i = 16'h0000;
      do_read("eis_sticky", 5'd13, 32'h0000_0001);
      do_read("nis_err_summary", 5'd12, 32'h0000_8000);
      check("irq_err_not_enabled", {31'h0, interrupt_o}, 32'h0);
      do_write(5'd13, 32'h0000_FFFF);
      do_read("eis_w1c", 5'd13, 32'h0);

      // completion edge collides with W1C of NIS bit0: set wins
      command_complete = 1'b1;
      do_write(5'd12, 32'h0000_0001);
      do_read("nis_set_wins", 5'd12, 32'h0000_0001);
      command_complete = 1'b0;
      tick();

      // soft reset
      do_write(5'd1, 32'h0000_0005);
      do_write(5'd0, 32'h0000_00A5);
      do_write(5'd11, 32'h0000_0001);
      do_read("sw_reset_high", 5'd11, 32'h0000_0001);
      do_read("sw_reset_selfclr", 5'd11, 32'h0);
      do_read("arg_after_swrst", 5'd0, 32'h0);
      do_read("cmd_after_swrst", 5'd1, 32'h0);
      do_read("inhibit_after_swrst", 5'd8, 32'h0);
      do_read("nie_after_swrst", 5'd14, 32'h0);

      // async reset mid-read
      do_write(5'd0, 32'h0000_0077);
      adr_i = 5'd0;
      reg_read_en = 1'b1;
      tick();
      check("pre_reset_read", data_o, 32'h0000_0077);
      #2;
      reset = 1'b0;
      #1;
      check("midread_valid", {31'h0, read_valid}, 32'h0);
      check("midread_data", data_o, 32'h0);
      reg_read_en = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      do_read("arg_after_async", 5'd0, 32'h0);

      // async reset mid-command
      do_write(5'd1, 32'h0000_0009);
      check("cmd_start_before_rst", {31'h0, cmd_start}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      check("midcmd_start", {31'h0, cmd_start}, 32'h0);
      check("midcmd_command", {16'h0, command_o}, 32'h0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_start_after_rst", {31'h0, cmd_start}, 32'h0);
      end
      do_read("cmd_after_async", 5'd1, 32'h0);
      do_read("present_after_async", 5'd8, 32'h0);

      // table-driven write/readback across the map
      hard_reset();
      for (int i = 0; i < 13; i++) begin
         do_write(vecs[i].adr, vecs[i].wdata);
         do_read($sformatf("vec%0d", i), vecs[i].adr, vecs[i].exp);
      end

      // randomized run against the reference model
      hard_reset();
      m_arg = 32'h0; m_blk = 32'h0; m_xfer = 32'h0; m_host = 32'h0; m_clk = 32'h0;
      m_dout = 32'h0; m_cmd = 16'h0; m_nis = 16'h0; m_eis = 16'h0; m_nie = 16'h0;
      m_eie = 16'h0; m_resp = 128'h0; m_inh = 1'b0; m_cc_prev = 1'b0;
      for (int c = 0; c < 400; c++) begin
         logic         we, re, ev, exp_start, exp_irq;
         logic [4:0]   a;
         logic [127:0] d, rsp;
         logic [15:0]  ni, ei, nclr, eclr;
         we = ($urandom_range(0, 2) == 0);
         re = ($urandom_range(0, 1) == 0);
         a = ($urandom_range(0, 3) == 0) ? 5'd1 : 5'($urandom_range(0, 19));
         if (a == 5'd11) we = 1'b0;
         d = {$urandom, $urandom, $urandom, $urandom};
         rsp = {$urandom, $urandom, $urandom, $urandom};
         ni = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
         ei = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'h0;
         if ($urandom_range(0, 5) == 0) command_complete = ~command_complete;
         adr_i = a; reg_write_en = we; reg_read_en = re; data_i = d;
         response_i = rsp; normal_interrupt_status_i = ni; error_interrupt_status_i = ei;

         ev = command_complete & ~m_cc_prev;
         m_cc_prev = command_complete;
         if (re) m_dout = m_read(a);
         exp_irq = (|(m_nis_view() & m_nie)) | (|(m_eis & m_eie));
         exp_start = we && (a == 5'd1) && !m_inh;
         nclr = 16'h0;
         eclr = 16'h0;
         if (we) begin
            case (a)
               5'd0:  m_arg = d[31:0];
               5'd1:  if (!m_inh) m_cmd = d[15:0];
               5'd2:  m_blk = d[31:0];
               5'd3:  m_xfer = d[31:0];
               5'd9:  m_host = d[31:0];
               5'd10: m_clk = d[31:0];
               5'd12: nclr = d[15:0];
               5'd13: eclr = d[15:0];
               5'd14: m_nie = d[15:0];
               5'd15: m_eie = d[15:0];
               default: ;
            endcase
         end
         m_nis = ((m_nis & ~nclr) | ni | {15'h0, ev}) & 16'h7FFF;
         m_eis = (m_eis & ~eclr) | ei;
         if (ev) m_resp = rsp;
         if (exp_start) m_inh = 1'b1;
         else if (ev) m_inh = 1'b0;

         tick();
         check("rnd_read_valid", {31'h0, read_valid}, {31'h0, re});
         check("rnd_data_o", data_o, m_dout);
         check("rnd_cmd_start", {31'h0, cmd_start}, {31'h0, exp_start});
         check("rnd_interrupt", {31'h0, interrupt_o}, {31'h0, exp_irq});
         check("rnd_argument", argument_o, m_arg);
         check("rnd_command", {16'h0, command_o}, {16'h0, m_cmd});
      end
      idle_inputs();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
